// File: rtl/drive_pkg.sv
// -----------------------------------------------------------------------------
// drive_pkg
// Shared definitions for the drive command serial transmitter.
//   - drive_state_t : frame FSM states
//   - NEUTRAL_CMD   : command sent after reset (no motion requested)
//   - DATA_BITS / PARITY_BITS / FRAME_BITS : serial frame geometry
//   - frame_byte()  : builds the 8-bit frame payload from a 6-bit command
//   - even_parity() : even parity over the 8 data bits
// Optional feature macro: DRIVE_CMD_PARITY_EN (adds one even-parity bit).
// -----------------------------------------------------------------------------
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } drive_state_t;

  localparam logic [5:0] NEUTRAL_CMD = 6'b100000;
  localparam int         DATA_BITS   = 8;

`ifdef DRIVE_CMD_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // start + data + optional parity + stop
  localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_BITS + 1;

  function automatic logic [7:0] frame_byte(input logic [5:0] c);
    return {2'b00, c};
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Free-running bit-period counter producing a one-cycle tick on the last
// clock of every BIT_CYCLES-clock bit period. i_clear holds the counter at
// zero so the first bit of a frame starts on a clean boundary.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   i_clear - hold counter at zero (no tick while asserted)
//   o_tick  - high on the final clock of each bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_tick
);

  localparam int             CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]  LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // bit-period counter, cleared on request and wrapping after LAST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {CW{1'b0}};
    end else if (r_cnt == LAST) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = ~i_clear & (r_cnt == LAST);

endmodule

// File: rtl/drive_cmd_tx.sv
// -----------------------------------------------------------------------------
// drive_cmd_tx
// Serialises 6-bit drive commands as UART-style frames (start, 8 data bits
// LSB first, optional even parity, stop) and periodically re-sends the last
// command while idle so the receiver never times out.
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   cmd         - drive command {2'b10, ~right, ~left, ~backward, ~forward}
//   cmd_valid   - cmd offered this cycle
//   cmd_ready   - command accepted this cycle (IDLE only)
//   tx          - serial output, idle high
//   busy        - frame in progress
//   frames_sent - completed frame count, wraps 255 -> 0
// Optional feature macro: DRIVE_CMD_PARITY_EN (even parity bit, 11-bit frame).
// -----------------------------------------------------------------------------
module drive_cmd_tx
  import drive_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int            BIT_CYCLES   = CLK_FREQ / BAUD;
  localparam int            RW           = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT     = 3'(DATA_BITS - 1);

  drive_state_t  r_state;
  logic [2:0]    r_bit_idx;
  logic [5:0]    r_last_cmd;
  logic [RW-1:0] r_refresh;
  logic          r_tx;
  logic          r_busy;
  logic          r_cmd_ready;
  logic [7:0]    r_frames;

  logic          w_handshake;
  logic          w_refresh_due;
  logic          w_tick;
  logic          w_clear;
  logic [7:0]    w_frame_byte;
  logic [2:0]    w_next_idx;

  assign w_handshake   = cmd_valid & r_cmd_ready;
  assign w_refresh_due = (r_refresh == REFRESH_LAST);
  // divider held in reset while idle so each frame starts a fresh bit period
  assign w_clear       = (r_state == IDLE);
  assign w_frame_byte  = frame_byte(r_last_cmd);
  assign w_next_idx    = r_bit_idx + 3'd1;

  baud_tick_gen #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // frame FSM with registered serial/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_idx   <= 3'd0;
      r_last_cmd  <= NEUTRAL_CMD;
      r_refresh   <= {RW{1'b0}};
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_frames    <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_handshake || w_refresh_due) begin
            // a new command wins over a coinciding refresh; both restart the count
            if (w_handshake) begin
              r_last_cmd <= cmd;
            end else begin
              r_last_cmd <= r_last_cmd;
            end
            r_state     <= START;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_refresh   <= {RW{1'b0}};
            r_bit_idx   <= 3'd0;
          end else begin
            r_refresh   <= r_refresh + RW'(1);
            r_cmd_ready <= 1'b1;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        START: begin
          r_refresh <= {RW{1'b0}};
          if (w_tick) begin
            r_state   <= DATA;
            r_tx      <= w_frame_byte[0];
            r_bit_idx <= 3'd0;
          end else begin
            r_state <= START;
          end
        end
        DATA: begin
          r_refresh <= {RW{1'b0}};
          if (w_tick) begin
            if (r_bit_idx == LAST_BIT) begin
`ifdef DRIVE_CMD_PARITY_EN
              r_state <= PARITY;
              r_tx    <= even_parity(w_frame_byte);
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= w_next_idx;
              r_tx      <= w_frame_byte[w_next_idx];
            end
          end else begin
            r_state <= DATA;
          end
        end
        PARITY: begin
          r_refresh <= {RW{1'b0}};
`ifdef DRIVE_CMD_PARITY_EN
          if (w_tick) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end else begin
            r_state <= PARITY;
          end
`else
          // unreachable without parity; fall back to a quiet idle line
          r_state     <= IDLE;
          r_tx        <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
`endif
        end
        STOP: begin
          r_refresh <= {RW{1'b0}};
          if (w_tick) begin
            r_state     <= IDLE;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_frames    <= r_frames + 8'd1;
          end else begin
            r_state <= STOP;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_tx        <= 1'b1;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_refresh   <= {RW{1'b0}};
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign busy        = r_busy;
  assign cmd_ready   = r_cmd_ready;
  assign frames_sent = r_frames;

endmodule

// File: doc/drive_cmd_tx.md
DRIVE_CMD_TX -- requirements
Module: drive_cmd_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 1_000_000, idle clocks between automatic re-sends of the last command.
REQ-004 SHALL have port clk, input, 1, system clock (P17, 100 MHz); all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port cmd, input, 6, drive command word {2'b10, ~right, ~left, ~backward, ~forward}.
REQ-007 SHALL have port cmd_valid, input, 1, cmd is offered this cycle.
REQ-008 SHALL have port cmd_ready, output, 1, block accepts cmd this cycle.
REQ-009 SHALL have port tx, output, 1, serial line to the car simulator, idle high.
REQ-010 SHALL have port busy, output, 1, a frame is in progress.
REQ-011 SHALL have port frames_sent, output, 8, count of completed frames, wraps 255->0.

Function
REQ-012 SHALL define BIT_CYCLES = CLK_FREQ/BAUD (integer division); every serial bit SHALL last exactly BIT_CYCLES clocks.
REQ-013 SHALL transmit frame byte {2'b00, cmd[5:0]}, LSB first: start bit 0, 8 data bits, optional parity (REQ-025), stop bit 1.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on handshake or refresh; START->DATA after one bit; DATA->PARITY (if enabled) or STOP after 8 bits; PARITY->STOP after one bit; STOP->IDLE after one bit.
REQ-015 SHALL assert cmd_ready only in IDLE; handshake = cmd_valid & cmd_ready; cmd SHALL be latched as last_cmd on handshake.
REQ-016 SHALL drive tx low on the clock cycle immediately after the handshake (latency 1).
REQ-017 SHALL ignore cmd_valid while busy; no queuing, no overwrite of the frame in flight.
REQ-018 SHALL count IDLE clocks; on reaching REFRESH_CYCLES-1 with no handshake, SHALL re-send last_cmd and restart the count.
REQ-019 SHALL, when handshake and refresh expiry coincide, send the new cmd once and restart the refresh count.
REQ-020 SHALL hold the refresh count at 0 while not in IDLE.
REQ-021 SHALL assert busy in every state except IDLE; SHALL increment frames_sent on the last clock of STOP.
REQ-022 SHALL restart the baud divider at each frame start; no fractional accumulation.

Reset
REQ-023 SHALL on rst, immediately and mid-frame: state IDLE, tx 1, busy 0, cmd_ready 0 while rst high, frames_sent 0, refresh count 0, last_cmd 6'b100000 (neutral); in-flight frame abandoned.
REQ-024 SHALL, after rst release, re-send neutral 6'b100000 after REFRESH_CYCLES idle clocks if no command arrives.

Configuration
REQ-025 SHALL support macro DRIVE_CMD_PARITY_EN: defined -> PARITY state sends even parity over the 8 data bits, frame 11 bits; undefined -> PARITY state unreachable, frame 10 bits.

Structure
REQ-026 SHALL place the state enum, NEUTRAL_CMD = 6'b100000 and frame-length constants in shared package drive_pkg.
REQ-027 SHALL instantiate one sub-module baud_tick_gen (counter, clear input, one-cycle tick every BIT_CYCLES clocks).

Verification (CLK_FREQ=1000, BAUD=100 -> BIT_CYCLES=10, REFRESH_CYCLES=50)
REQ-028 SHALL check: cmd=6'b101010 with cmd_valid for 1 cycle -> tx low next cycle, then bits 0,1,0,1,0,1,0,0 each 10 cycles, stop high, frames_sent=1 after 100 cycles.
REQ-029 SHALL check: cmd_valid held during frame with cmd=6'b100001 -> cmd_ready 0 and first frame unchanged; second frame 6'b100001 starts the cycle after return to IDLE.
REQ-030 SHALL check: no input after frame of 6'b101010 -> identical frame re-sent after 50 idle cycles, repeating.
REQ-031 SHALL check: rst pulsed at bit 4 of a frame -> tx 1 same cycle, frames_sent 0, neutral 6'b100000 sent 50 cycles after release.
REQ-032 SHALL check: DRIVE_CMD_PARITY_EN defined, cmd=6'b100011 -> parity bit 1, 110-cycle frame; undefined -> 100-cycle frame.
REQ-033 SHALL check: 256 frames -> frames_sent wraps to 0.
